// File: rtl/xor_invert_pipe.sv
// xor_invert_pipe -- two-stage valid/ready pipeline computing a per-op
// bitwise function of two operands.
//
//   op 00 : a ^ b      op 01 : ~(a ^ b)
//   op 10 : ~a         op 11 : a
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   in_valid/in_ready  input handshake; in_a, in_b, op sampled with it
//   out_valid/out_ready output handshake; out_data driven from stage S2
//   xfer_count         count of output handshakes, wraps silently
//   out_parity         ^out_data, registered with S2
//                      (only with XOR_INVERT_PIPE_PARITY_EN defined)
//
// Stage S1 captures the combinational result; S2 drives the outputs.
// in_ready is combinational from out_ready so a full pipe can accept
// and emit in the same cycle without a bubble.
module xor_invert_pipe #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
`ifdef XOR_INVERT_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           s1, s2;
  logic [WIDTH-1:0] res;
  logic             in_hs, out_hs, s1_adv;

  always_comb begin
    res = '0;
    unique case (op)
      2'b00: res = in_a ^ in_b;
      2'b01: res = ~(in_a ^ in_b);
      2'b10: res = ~in_a;
      2'b11: res = in_a;
    endcase
  end

  assign out_hs   = s2.vld && out_ready;
  // S1 moves on when S2 is empty or is draining this very cycle
  assign s1_adv   = s1.vld && (!s2.vld || out_hs);
  // gated by rst_n: flags are already clear in reset, but the port must read 0
  assign in_ready = rst_n && (!s1.vld || s1_adv);
  assign in_hs    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1     <= '0;
    else if (in_hs)  s1     <= '{vld: 1'b1, data: res};
    else if (s1_adv) s1.vld <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s2     <= '0;
    else if (s1_adv) s2     <= s1;
    else if (out_hs) s2.vld <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      xfer_count <= '0;
    else if (out_hs) xfer_count <= xfer_count + 1'b1;
  end

  assign out_valid = s2.vld;
  assign out_data  = s2.data;

`ifdef XOR_INVERT_PIPE_PARITY_EN
  // registered with S2 data so it tracks out_data exactly under stall
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_q <= 1'b0;
    else if (s1_adv) par_q <= ^s1.data;
  end
  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_xor_invert_pipe.sv
// Directed bench for xor_invert_pipe (WIDTH=10). A second instance with
// CNT_W=2 shares the stimulus and is only inspected for counter wrap.
module tb_xor_invert_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [9:0] in_a, in_b;
  logic [1:0] op;
  logic       in_ready, out_valid;
  logic [9:0] out_data;
  logic [15:0] xfer_count;
  logic       in_ready2, out_valid2;
  logic [9:0] out_data2;
  logic [1:0] xfer_count2;
`ifdef XOR_INVERT_PIPE_PARITY_EN
  logic       out_parity, out_parity2;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [9:0] q[$];
  logic       ihs, ohs;

  always #5 clk = ~clk;

  xor_invert_pipe #(.WIDTH(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_count(xfer_count)
`ifdef XOR_INVERT_PIPE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  xor_invert_pipe #(.WIDTH(10), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .op(op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .xfer_count(xfer_count2)
`ifdef XOR_INVERT_PIPE_PARITY_EN
    , .out_parity(out_parity2)
`endif
  );

  function automatic logic [9:0] ref_op(logic [9:0] a, logic [9:0] b, logic [1:0] o);
    case (o)
      2'b00:   return a ^ b;
      2'b01:   return ~(a ^ b);
      2'b10:   return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; op = '0;

    // reset state
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_xfer", 32'(xfer_count), 0);
`ifdef XOR_INVERT_PIPE_PARITY_EN
    chk("rst_parity", 32'(out_parity), 0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // single op=00, latency 2
    out_ready = 1'b1; in_valid = 1'b1;
    in_a = 10'h2AA; in_b = 10'h0F0; op = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    chk("xor_valid", 32'(out_valid), 1);
    chk("xor_data", 32'(out_data), 32'h25A);
`ifdef XOR_INVERT_PIPE_PARITY_EN
    chk("xor_parity", 32'(out_parity), 1);
`endif
    tick();
    chk("xor_drained", 32'(out_valid), 0);
    chk("xor_xfer", 32'(xfer_count), 1);

    // back-to-back op 01,10,11
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_a = 10'h2AA; in_b = 10'h0F0; op = 2'b01;
    tick(); op = 2'b10;
    tick(); op = 2'b11;
    chk("b2b_d0", 32'(out_data), 32'h1A5);
    chk("b2b_x0", 32'(xfer_count), 0);
    tick(); in_valid = 1'b0;
    chk("b2b_d1", 32'(out_data), 32'h155);
    chk("b2b_x1", 32'(xfer_count), 1);
    tick();
    chk("b2b_d2", 32'(out_data), 32'h2AA);
    chk("b2b_x2", 32'(xfer_count), 2);
    tick();
    chk("b2b_empty", 32'(out_valid), 0);
    chk("b2b_x3", 32'(xfer_count), 3);

    // backpressure: in_ready 1,1,0 then drain in order
    do_reset();
    in_valid = 1'b1; in_a = 10'h2AA; in_b = 10'h0F0; op = 2'b00;
    #1; chk("bp_rdy0", 32'(in_ready), 1);
    tick(); op = 2'b01;
    #1; chk("bp_rdy1", 32'(in_ready), 1);
    tick(); op = 2'b10;
    #1; chk("bp_rdy2", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data0", 32'(out_data), 32'h25A);
    in_valid = 1'b0;
    tick();
    chk("bp_hold", 32'(out_data), 32'h25A);
`ifdef XOR_INVERT_PIPE_PARITY_EN
    chk("bp_hold_par", 32'(out_parity), 1);
`endif
    chk("bp_full_rdy", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    chk("bp_data1", 32'(out_data), 32'h1A5);
    chk("bp_xfer1", 32'(xfer_count), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);
    chk("bp_xfer2", 32'(xfer_count), 2);

    // toggling out_ready under continuous in_valid, scoreboard
    do_reset();
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; in_a = 10'(i * 37 + 5); in_b = 10'(i * 91 + 3);
      op = 2'(i); out_ready = i[0];
      #1;
      ihs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (ohs) begin
        if (q.size() == 0) chk("seq_extra", 32'(out_data), 32'hFFFF_FFFF);
        else chk("seq_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (ihs) q.push_back(ref_op(in_a, in_b, op));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("seq_extra", 32'(out_data), 32'hFFFF_FFFF);
        else chk("seq_data", 32'(out_data), 32'(q.pop_front()));
      end
      tick();
    end
    chk("seq_left", 32'(q.size()), 0);
    chk("seq_idle", 32'(out_valid), 0);

    // mid-operation reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; in_a = 10'h123; in_b = 10'h0; op = 2'b11;
    tick(); in_a = 10'h0FF;
    tick(); in_valid = 1'b0;
    chk("mr_full", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_xfer", 32'(xfer_count), 0);
    chk("mr_data", 32'(out_data), 0);
    chk("mr_rdy", 32'(in_ready), 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_stale", 32'(out_valid), 0);
    end

    // counter wrap on the CNT_W=2 instance
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 10'h001; in_b = 10'h002; op = 2'b00;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_wide", 32'(xfer_count), 5);
    chk("wrap_cnt2", 32'(xfer_count2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
